// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: coin codes, FSM state
// encodings and the coin-code to nickel-unit conversion.
package vend_pkg;

   // Coin acceptor codes; 3'b110 and 3'b111 are not legal coins.
   localparam logic [2:0] COIN_NONE        = 3'b000;
   localparam logic [2:0] COIN_NICKEL      = 3'b001;
   localparam logic [2:0] COIN_DIME        = 3'b010;
   localparam logic [2:0] COIN_NICKEL_DIME = 3'b011;
   localparam logic [2:0] COIN_DIME_DIME   = 3'b100;
   localparam logic [2:0] COIN_QUARTER     = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_COLLECT = 3'b001,
      ST_VEND    = 3'b010,
      ST_CHANGE  = 3'b011
   } state_e;

   // Value of a coin code in nickel units; illegal codes and "none" are worth 0.
   function automatic logic [2:0] coin_value(input logic [2:0] code);
      case (code)
         COIN_NICKEL:      coin_value = 3'd1;
         COIN_DIME:        coin_value = 3'd2;
         COIN_NICKEL_DIME: coin_value = 3'd3;
         COIN_DIME_DIME:   coin_value = 3'd4;
         COIN_QUARTER:     coin_value = 3'd5;
         default:          coin_value = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Change picker: offers the largest single coin (quarter, dime, nickel)
// that does not exceed the remaining credit, so credit can never underflow.
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 4
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [2:0]          change_coin,
   output logic [2:0]          change_value
);

   // Largest-first coin selection.
   always_comb begin
      change_coin = COIN_NONE;
      if (credit >= CREDIT_W'(5)) begin
         change_coin = COIN_QUARTER;
      end else if (credit >= CREDIT_W'(2)) begin
         change_coin = COIN_DIME;
      end else if (credit != '0) begin
         change_coin = COIN_NICKEL;
      end
      change_value = coin_value(change_coin);
   end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vending controller: accumulates coin credit, latches a product selection,
// hands off to the dispenser, then pays change one coin per handshake.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 15,
   parameter int PRICE0     = 3,
   parameter int PRICE1     = 4,
   parameter int PRICE2     = 5,
   parameter int PRICE3     = 7
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          coin,
   input  logic                sel_valid,
   input  logic [1:0]          sel,
   input  logic                cancel,
   input  logic                disp_ready,
   input  logic                ret_ready,
   output logic                vend,
   output logic [1:0]          vend_sel,
   output logic                change_valid,
   output logic [2:0]          change_coin,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [2:0]          state
);

   state_e                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic                  vend_q, vend_d;
   logic [1:0]            vend_sel_q, vend_sel_d;
   logic                  sel_latched_q, sel_latched_d;
   logic                  change_valid_q, change_valid_d;
   logic [2:0]            change_coin_q, change_coin_d;
   logic [2:0]            change_amt_q, change_amt_d;
   logic                  coin_reject_q, coin_reject_d;

   logic [CREDIT_W-1:0]   price;
   logic [2:0]            coin_val;
   logic [CREDIT_W:0]     coin_sum;
   logic                  coin_fits;
   logic [CREDIT_W-1:0]   change_left;
   logic [2:0]            pick_coin;
   logic [2:0]            pick_value;

   // Coin acceptance: one spare bit on the sum so an over-ceiling coin cannot wrap.
   assign coin_val    = coin_value(coin);
   assign coin_sum    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
   assign coin_fits   = (coin_val != 3'd0) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
   assign change_left = credit_q - CREDIT_W'(change_amt_q);

   // Price of the latched product.
   always_comb begin
      price = CREDIT_W'(PRICE0);
      case (vend_sel_q)
         2'd1:    price = CREDIT_W'(PRICE1);
         2'd2:    price = CREDIT_W'(PRICE2);
         2'd3:    price = CREDIT_W'(PRICE3);
         default: price = CREDIT_W'(PRICE0);
      endcase
   end

   // Next state, credit, selection, vend request and coin rejection.
   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      vend_sel_d    = vend_sel_q;
      sel_latched_d = sel_latched_q;
      vend_d        = 1'b0;
      coin_reject_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (coin_fits) begin
               credit_d = coin_sum[CREDIT_W-1:0];
            end else if (coin != COIN_NONE) begin
               coin_reject_d = 1'b1;
            end
            if (state_q == ST_IDLE) begin
               if (coin_fits) begin
                  state_d = ST_COLLECT;
               end
               if (sel_valid) begin
                  vend_sel_d    = sel;
                  sel_latched_d = 1'b1;
               end
            end else if (cancel) begin
               // Abort drops the selection along with refunding the credit.
               state_d       = ST_CHANGE;
               sel_latched_d = 1'b0;
            end else if (sel_latched_q && (credit_q >= price)) begin
               // Selection is frozen on the way into VEND so the product that
               // passed the price check is the one charged.
               state_d = ST_VEND;
            end else if (sel_valid) begin
               vend_sel_d    = sel;
               sel_latched_d = 1'b1;
            end
         end
         ST_VEND: begin
            coin_reject_d = (coin != COIN_NONE);
            if (vend_q && disp_ready) begin
               credit_d      = credit_q - price;
               sel_latched_d = 1'b0;
               state_d       = (credit_q == price) ? ST_IDLE : ST_CHANGE;
            end else begin
               vend_d = 1'b1;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = (coin != COIN_NONE);
            if (change_valid_q && ret_ready) begin
               credit_d = change_left;
            end
            if (credit_d == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            coin_reject_d = (coin != COIN_NONE);
            state_d       = ST_IDLE;
            credit_d      = '0;
            sel_latched_d = 1'b0;
         end
      endcase
   end

   vend_change_sel #(
      .CREDIT_W (CREDIT_W)
   ) u_change_sel (
      .credit       (credit_d),
      .change_coin  (pick_coin),
      .change_value (pick_value)
   );

   // Change request for the credit that will be held next cycle.
   always_comb begin
      change_valid_d = 1'b0;
      change_coin_d  = COIN_NONE;
      change_amt_d   = 3'd0;
      if ((state_q == ST_CHANGE) && (state_d == ST_CHANGE)) begin
         change_valid_d = 1'b1;
         change_coin_d  = pick_coin;
         change_amt_d   = pick_value;
      end
   end

   // Registered state and outputs with synchronous reset.
   // NOTE: non-blocking assignments keep every flop sampling pre-edge values, avoiding order races.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         vend_q         <= 1'b0;
         vend_sel_q     <= 2'd0;
         sel_latched_q  <= 1'b0;
         change_valid_q <= 1'b0;
         change_coin_q  <= COIN_NONE;
         change_amt_q   <= 3'd0;
         coin_reject_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         vend_q         <= vend_d;
         vend_sel_q     <= vend_sel_d;
         sel_latched_q  <= sel_latched_d;
         change_valid_q <= change_valid_d;
         change_coin_q  <= change_coin_d;
         change_amt_q   <= change_amt_d;
         coin_reject_q  <= coin_reject_d;
      end
   end

   assign vend         = vend_q;
   assign vend_sel     = vend_sel_q;
   assign change_valid = change_valid_q;
   assign change_coin  = change_coin_q;
   assign coin_reject  = coin_reject_q;
   assign credit       = credit_q;
   assign state        = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed, table-driven bench for vend_dispense_ctrl plus hand-written
// sequences for the stalled-vend and mid-operation reset corner cases.
module tb_vend_dispense_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_COLL = 3'd1, S_VEND = 3'd2, S_CHG = 3'd3;
   localparam logic [2:0] NONE = 3'd0, NK = 3'd1, DM = 3'd2, NKDM = 3'd3, DMDM = 3'd4, QT = 3'd5, BAD = 3'd6;

   logic       clk, rst;
   logic [2:0] coin;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel, disp_ready, ret_ready;
   logic       vend, change_valid, coin_reject;
   logic [1:0] vend_sel;
   logic [2:0] change_coin, state;
   logic [3:0] credit;

   typedef struct {
      int         tid;
      logic       rst;
      logic [2:0] coin;
      logic       sv;
      logic [1:0] sel;
      logic       cancel;
      logic       dr;
      logic       rr;
      logic [14:0] exp;  // {state, credit, vend, vend_sel, change_valid, change_coin, coin_reject}
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   vend_dispense_ctrl dut (
      .clock        (clk),
      .reset        (rst),
      .coin         (coin),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .disp_ready   (disp_ready),
      .ret_ready    (ret_ready),
      .vend         (vend),
      .vend_sel     (vend_sel),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .coin_reject  (coin_reject),
      .credit       (credit),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input int tid, input logic r, input logic [2:0] c, input logic sv,
                      input logic [1:0] s, input logic cn, input logic dr, input logic rr,
                      input logic [2:0] e_st, input logic [3:0] e_cr, input logic e_v,
                      input logic [1:0] e_vs, input logic e_cv, input logic [2:0] e_cc,
                      input logic e_rej);
      vec_t v;
      v.tid = tid; v.rst = r; v.coin = c; v.sv = sv; v.sel = s;
      v.cancel = cn; v.dr = dr; v.rr = rr;
      v.exp = {e_st, e_cr, e_v, e_vs, e_cv, e_cc, e_rej};
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs away from the edge, then settle past the edge.
   task automatic drive(input logic r, input logic [2:0] c, input logic sv, input logic [1:0] s,
                        input logic cn, input logic dr, input logic rr);
      @(negedge clk);
      rst = r; coin = c; sel_valid = sv; sel = s; cancel = cn; disp_ready = dr; ret_ready = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [14:0] exp);
      logic [14:0] act;
      act = {state, credit, vend, vend_sel, change_valid, change_coin, coin_reject};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got st=%0d cr=%0d vend=%0b vs=%0d cv=%0b cc=%0d rej=%0b, want st=%0d cr=%0d vend=%0b vs=%0d cv=%0b cc=%0d rej=%0b",
                  tag, act[14:12], act[11:8], act[7], act[6:5], act[4], act[3:1], act[0],
                  exp[14:12], exp[11:8], exp[7], exp[6:5], exp[4], exp[3:1], exp[0]);
      end
   endtask

   initial begin
      int waited;
      rst = 1'b0; coin = NONE; sel_valid = 1'b0; sel = 2'd0;
      cancel = 1'b0; disp_ready = 1'b0; ret_ready = 1'b0;

      // tid, rst, coin, sv, sel, cancel, dr, rr | state, credit, vend, vend_sel, cv, cc, rej
      // 1: quarter buys product 0, one dime back
      add(1, 1, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 0, 0, NONE, 0);
      add(1, 0, QT,   1, 0, 0, 0, 0,  S_COLL, 5, 0, 0, 0, NONE, 0);
      add(1, 0, NONE, 0, 0, 0, 0, 0,  S_VEND, 5, 0, 0, 0, NONE, 0);
      add(1, 0, NONE, 0, 0, 0, 0, 0,  S_VEND, 5, 1, 0, 0, NONE, 0);
      add(1, 0, NONE, 0, 0, 0, 1, 0,  S_CHG,  2, 0, 0, 0, NONE, 0);
      add(1, 0, NONE, 0, 0, 0, 0, 0,  S_CHG,  2, 0, 0, 1, DM,   0);
      add(1, 0, NONE, 0, 0, 0, 0, 1,  S_IDLE, 0, 0, 0, 0, NONE, 0);
      // 2: product 3 for seven nickels, exact change, no payout
      add(2, 1, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 0, 0, NONE, 0);
      add(2, 0, NONE, 1, 3, 0, 0, 0,  S_IDLE, 0, 0, 3, 0, NONE, 0);
      for (int k = 1; k <= 7; k++)
         add(2, 0, NK, 0, 0, 0, 0, 0, S_COLL, 4'(k), 0, 3, 0, NONE, 0);
      add(2, 0, NONE, 0, 0, 0, 0, 0,  S_VEND, 7, 0, 3, 0, NONE, 0);
      add(2, 0, NONE, 0, 0, 0, 0, 0,  S_VEND, 7, 1, 3, 0, NONE, 0);
      add(2, 0, NONE, 0, 0, 0, 1, 0,  S_IDLE, 0, 0, 3, 0, NONE, 0);
      add(2, 0, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 3, 0, NONE, 0);
      // 3: credit ceiling, illegal code, then refund of 15 with ret_ready held
      add(3, 1, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0,  0, 0, 0, NONE, 0);
      add(3, 0, QT,   0, 0, 0, 0, 0,  S_COLL, 5,  0, 0, 0, NONE, 0);
      add(3, 0, QT,   0, 0, 0, 0, 0,  S_COLL, 10, 0, 0, 0, NONE, 0);
      add(3, 0, NKDM, 0, 0, 0, 0, 0,  S_COLL, 13, 0, 0, 0, NONE, 0);
      add(3, 0, QT,   0, 0, 0, 0, 0,  S_COLL, 13, 0, 0, 0, NONE, 1);
      add(3, 0, NKDM, 0, 0, 0, 0, 0,  S_COLL, 13, 0, 0, 0, NONE, 1);
      add(3, 0, BAD,  0, 0, 0, 0, 0,  S_COLL, 13, 0, 0, 0, NONE, 1);
      add(3, 0, DM,   0, 0, 0, 0, 0,  S_COLL, 15, 0, 0, 0, NONE, 0);
      add(3, 0, NK,   0, 0, 0, 0, 0,  S_COLL, 15, 0, 0, 0, NONE, 1);
      add(3, 0, NONE, 0, 0, 1, 0, 0,  S_CHG,  15, 0, 0, 0, NONE, 0);
      add(3, 0, NONE, 0, 0, 0, 0, 1,  S_CHG,  15, 0, 0, 1, QT,   0);
      add(3, 0, NONE, 0, 0, 0, 0, 1,  S_CHG,  10, 0, 0, 1, QT,   0);
      add(3, 0, NONE, 0, 0, 0, 0, 1,  S_CHG,  5,  0, 0, 1, QT,   0);
      add(3, 0, NONE, 0, 0, 0, 0, 1,  S_IDLE, 0,  0, 0, 0, NONE, 0);
      // 4: cancel with 6 units: quarter then nickel
      add(4, 1, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 0, 0, NONE, 0);
      add(4, 0, DM,   0, 0, 0, 0, 0,  S_COLL, 2, 0, 0, 0, NONE, 0);
      add(4, 0, DMDM, 0, 0, 0, 0, 0,  S_COLL, 6, 0, 0, 0, NONE, 0);
      add(4, 0, NONE, 0, 0, 1, 0, 0,  S_CHG,  6, 0, 0, 0, NONE, 0);
      add(4, 0, NONE, 0, 0, 0, 0, 0,  S_CHG,  6, 0, 0, 1, QT,   0);
      add(4, 0, NONE, 0, 0, 0, 0, 1,  S_CHG,  1, 0, 0, 1, NK,   0);
      add(4, 0, NONE, 0, 0, 0, 0, 1,  S_IDLE, 0, 0, 0, 0, NONE, 0);
      // 5: selection overwrite, then cancel beats a ready vend
      add(5, 1, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 0, 0, NONE, 0);
      add(5, 0, NONE, 1, 1, 0, 0, 0,  S_IDLE, 0, 0, 1, 0, NONE, 0);
      add(5, 0, NONE, 1, 2, 0, 0, 0,  S_IDLE, 0, 0, 2, 0, NONE, 0);
      add(5, 0, QT,   0, 0, 0, 0, 0,  S_COLL, 5, 0, 2, 0, NONE, 0);
      add(5, 0, NONE, 0, 0, 1, 0, 0,  S_CHG,  5, 0, 2, 0, NONE, 0);
      add(5, 0, NONE, 0, 0, 0, 0, 0,  S_CHG,  5, 0, 2, 1, QT,   0);
      add(5, 0, NONE, 0, 0, 0, 0, 1,  S_IDLE, 0, 0, 2, 0, NONE, 0);
      add(5, 0, NONE, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 2, 0, NONE, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].coin, vecs[i].sv, vecs[i].sel,
               vecs[i].cancel, vecs[i].dr, vecs[i].rr);
         check($sformatf("t%0d.%0d", vecs[i].tid, i), vecs[i].exp);
      end

      // 6: stalled vend rejects coins and ignores cancel; reset discards credit
      drive(1, NONE, 0, 0, 0, 0, 0);
      check("t6.reset", {S_IDLE, 4'd0, 1'b0, 2'd0, 1'b0, NONE, 1'b0});
      drive(0, QT, 1, 1, 0, 0, 0);
      check("t6.coin", {S_COLL, 4'd5, 1'b0, 2'd1, 1'b0, NONE, 1'b0});
      waited = 0;
      while (vend !== 1'b1 && waited < 6) begin
         drive(0, NONE, 0, 0, 0, 0, 0);
         waited++;
      end
      n_vec++;
      if (waited != 2) begin
         n_bad++;
         $display("FAIL t6.vend_latency: got %0d cycles, want 2", waited);
      end
      check("t6.vend_up", {S_VEND, 4'd5, 1'b1, 2'd1, 1'b0, NONE, 1'b0});
      for (int k = 0; k < 3; k++) begin
         drive(0, DM, 0, 0, (k == 1), 0, 0);
         check($sformatf("t6.stall%0d", k), {S_VEND, 4'd5, 1'b1, 2'd1, 1'b0, NONE, 1'b1});
      end
      drive(1, DM, 0, 0, 0, 0, 0);
      check("t6.mid_reset", {S_IDLE, 4'd0, 1'b0, 2'd0, 1'b0, NONE, 1'b0});
      drive(0, NONE, 0, 0, 0, 1, 1);
      check("t6.after", {S_IDLE, 4'd0, 1'b0, 2'd0, 1'b0, NONE, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
